// File: rtl/bus_if_arbiter_if.sv
// Bus package and Bus_if interface used by bus_if_arbiter.
//
// Bus      : command / response encodings and field widths.
// bus_if_arbiter_if : one Bus_if link.
//    master modport : drives MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n;
//                     receives SCmdAccept, SResp, SData.
//    slave modport  : the mirror image.
package Bus;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } cmd_e;

   typedef enum logic [1:0] {
      NULL = 2'd0,
      DVA  = 2'd1,
      ERR  = 2'd2
   } resp_e;
endpackage

interface bus_if_arbiter_if;
   Bus::cmd_e                MCmd;
   logic [Bus::ADDR_W-1:0]   MAddr;
   logic [Bus::DATA_W-1:0]   MData;
   logic [Bus::BE_W-1:0]     MByteEn;
   logic                     MRespAccept;
   logic                     MReset_n;
   logic                     SCmdAccept;
   Bus::resp_e               SResp;
   logic [Bus::DATA_W-1:0]   SData;

   modport master (
      output MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n,
      input  SCmdAccept, SResp, SData
   );

   modport slave (
      input  MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n,
      output SCmdAccept, SResp, SData
   );
endinterface

// File: rtl/bus_if_arbiter.sv
// bus_if_arbiter: shares one Bus_if slave between two Bus_if masters.
// Commands are forwarded combinationally from the winning master; the id of
// every accepted command is queued so that responses, which the slave returns
// in issue order, are steered back to the master that issued them.
//
// Ports
//    Clk    : system clock
//    Reset  : asynchronous, active-high reset
//    in_0   : requester 0 (slave modport)
//    in_1   : requester 1 (slave modport)
//    out    : shared target (master modport), out.MReset_n = ~Reset
//
// Parameter
//    NUM_IN_FLIGHT : depth of the id FIFO = max accepted-but-unanswered commands
//
// Build option
//    BUS_IF_ARBITER_FIXED_PRIO_EN : when defined, in_0 always wins a tie in ARB
//    (no round-robin pointer); otherwise ties alternate via rr_ptr.
module bus_if_arbiter #(
   parameter int NUM_IN_FLIGHT = 4
) (
   input logic              Clk,
   input logic              Reset,
   bus_if_arbiter_if.slave  in_0,
   bus_if_arbiter_if.slave  in_1,
   bus_if_arbiter_if.master out
);

   localparam int CW = $clog2(NUM_IN_FLIGHT + 1);
   localparam int PW = (NUM_IN_FLIGHT > 1) ? $clog2(NUM_IN_FLIGHT) : 1;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      LOCK_0 = 2'd1,
      LOCK_1 = 2'd2
   } state_e;

   state_e                   state;
   state_e                   state_next;
   logic [NUM_IN_FLIGHT-1:0] ids;
   logic [PW-1:0]            wr_ptr;
   logic [PW-1:0]            rd_ptr;
   logic [CW-1:0]            count;

   logic req_0;
   logic req_1;
   logic full;
   logic empty;
   logic winner_valid;
   logic winner_id;
   logic fwd;
   logic push;
   logic pop;
   logic head_id;
   logic head_accept;
   logic route;

`ifndef BUS_IF_ARBITER_FIXED_PRIO_EN
   logic rr_ptr;
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(NUM_IN_FLIGHT - 1)) begin
         return '0;
      end else begin
         return p + PW'(1);
      end
   endfunction

   assign req_0 = (in_0.MCmd != Bus::IDLE);
   assign req_1 = (in_1.MCmd != Bus::IDLE);
   assign full  = (count == CW'(NUM_IN_FLIGHT));
   assign empty = (count == CW'(0));

   // Winner selection: a locked grant is kept until its command is accepted.
   always_comb begin
      winner_valid = 1'b0;
      winner_id    = 1'b0;
      case (state)
         LOCK_0: begin
            winner_valid = req_0;
            winner_id    = 1'b0;
         end
         LOCK_1: begin
            winner_valid = req_1;
            winner_id    = 1'b1;
         end
         ARB: begin
            if (req_0 && req_1) begin
               winner_valid = 1'b1;
`ifdef BUS_IF_ARBITER_FIXED_PRIO_EN
               winner_id    = 1'b0;
`else
               winner_id    = rr_ptr;
`endif
            end else if (req_0) begin
               winner_valid = 1'b1;
               winner_id    = 1'b0;
            end else if (req_1) begin
               winner_valid = 1'b1;
               winner_id    = 1'b1;
            end else begin
               winner_valid = 1'b0;
               winner_id    = 1'b0;
            end
         end
         default: begin
            winner_valid = 1'b0;
            winner_id    = 1'b0;
         end
      endcase
   end

   // Command forwarding; address/data fields follow the winner, in_0 when idle.
   always_comb begin
      fwd             = !Reset && !full && winner_valid;
      out.MCmd        = Bus::IDLE;
      out.MAddr       = in_0.MAddr;
      out.MData       = in_0.MData;
      out.MByteEn     = in_0.MByteEn;
      in_0.SCmdAccept = 1'b0;
      in_1.SCmdAccept = 1'b0;
      if (winner_id) begin
         out.MAddr   = in_1.MAddr;
         out.MData   = in_1.MData;
         out.MByteEn = in_1.MByteEn;
      end else begin
         out.MAddr   = in_0.MAddr;
         out.MData   = in_0.MData;
         out.MByteEn = in_0.MByteEn;
      end
      if (fwd) begin
         out.MCmd        = winner_id ? in_1.MCmd : in_0.MCmd;
         in_0.SCmdAccept = !winner_id && out.SCmdAccept;
         in_1.SCmdAccept = winner_id && out.SCmdAccept;
      end else begin
         out.MCmd        = Bus::IDLE;
      end
   end

   assign push = fwd && out.SCmdAccept;

   // Response steering to the master at the head of the id FIFO.
   always_comb begin
      head_id         = ids[rd_ptr];
      route           = !Reset && !empty;
      head_accept     = head_id ? in_1.MRespAccept : in_0.MRespAccept;
      in_0.SResp      = Bus::NULL;
      in_0.SData      = '0;
      in_1.SResp      = Bus::NULL;
      in_1.SData      = '0;
      out.MRespAccept = 1'b0;
      if (route) begin
         out.MRespAccept = head_accept;
         if (head_id) begin
            in_1.SResp = out.SResp;
            in_1.SData = out.SData;
         end else begin
            in_0.SResp = out.SResp;
            in_0.SData = out.SData;
         end
      end else begin
         out.MRespAccept = 1'b0;
      end
   end

   assign pop          = route && (out.SResp != Bus::NULL) && head_accept;
   assign out.MReset_n = ~Reset;

   // Next-state logic; a full FIFO freezes the FSM.
   always_comb begin
      state_next = state;
      if (full) begin
         state_next = state;
      end else begin
         case (state)
            ARB: begin
               if (winner_valid && !out.SCmdAccept) begin
                  state_next = winner_id ? LOCK_1 : LOCK_0;
               end else begin
                  state_next = ARB;
               end
            end
            LOCK_0, LOCK_1: begin
               if (push) begin
                  state_next = ARB;
               end else begin
                  state_next = state;
               end
            end
            default: state_next = ARB;
         endcase
      end
   end

   // FSM state and id FIFO registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= ARB;
         ids    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         state <= state_next;
         if (push) begin
            ids[wr_ptr] <= winner_id;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifndef BUS_IF_ARBITER_FIXED_PRIO_EN
   // Round-robin pointer: after a grant, the other master is preferred.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rr_ptr <= 1'b0;
      end else if (push) begin
         rr_ptr <= ~winner_id;
      end else begin
         rr_ptr <= rr_ptr;
      end
   end
`endif

endmodule

// File: tb/tb_bus_if_arbiter.sv
module tb_bus_if_arbiter;

   localparam int DEPTH = 4;
`ifdef BUS_IF_ARBITER_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic Clk   = 1'b0;
   logic Reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   bus_if_arbiter_if in_0_bus ();
   bus_if_arbiter_if in_1_bus ();
   bus_if_arbiter_if out_bus ();

   bus_if_arbiter #(.NUM_IN_FLIGHT(DEPTH)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .in_0  (in_0_bus),
      .in_1  (in_1_bus),
      .out   (out_bus)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: queue of issuer ids ----------------
   int q[$];
   int locked = -1;
   int pref   = 0;

   task automatic model_step();
      logic r0, r1, full, fwd, a0, a1, hacc;
      int   owner, head;
      Bus::cmd_e exp_cmd;
      if (Reset) begin
         check("rst out.MCmd", out_bus.MCmd, Bus::IDLE);
         check("rst in_0.SCmdAccept", in_0_bus.SCmdAccept, 1'b0);
         check("rst in_1.SCmdAccept", in_1_bus.SCmdAccept, 1'b0);
         check("rst in_0.SResp", in_0_bus.SResp, Bus::NULL);
         check("rst in_1.SResp", in_1_bus.SResp, Bus::NULL);
         check("rst in_0.SData", in_0_bus.SData, 32'h0);
         check("rst in_1.SData", in_1_bus.SData, 32'h0);
         check("rst out.MRespAccept", out_bus.MRespAccept, 1'b0);
         check("rst out.MReset_n", out_bus.MReset_n, 1'b0);
         q.delete();
         locked = -1;
         pref   = 0;
         return;
      end
      r0   = (in_0_bus.MCmd != Bus::IDLE);
      r1   = (in_1_bus.MCmd != Bus::IDLE);
      full = (q.size() == DEPTH);
      if (locked >= 0)      owner = ((locked == 0) ? r0 : r1) ? locked : -1;
      else if (r0 && r1)    owner = FIXED ? 0 : pref;
      else if (r0)          owner = 0;
      else if (r1)          owner = 1;
      else                  owner = -1;
      fwd     = !full && (owner >= 0);
      exp_cmd = !fwd ? Bus::IDLE : ((owner == 1) ? in_1_bus.MCmd : in_0_bus.MCmd);
      check("out.MCmd", out_bus.MCmd, exp_cmd);
      check("out.MAddr", out_bus.MAddr, (owner == 1) ? in_1_bus.MAddr : in_0_bus.MAddr);
      check("out.MData", out_bus.MData, (owner == 1) ? in_1_bus.MData : in_0_bus.MData);
      check("out.MByteEn", out_bus.MByteEn, (owner == 1) ? in_1_bus.MByteEn : in_0_bus.MByteEn);
      a0 = fwd && (owner == 0) && out_bus.SCmdAccept;
      a1 = fwd && (owner == 1) && out_bus.SCmdAccept;
      check("in_0.SCmdAccept", in_0_bus.SCmdAccept, a0);
      check("in_1.SCmdAccept", in_1_bus.SCmdAccept, a1);
      head = (q.size() > 0) ? q[0] : -1;
      check("in_0.SResp", in_0_bus.SResp, (head == 0) ? out_bus.SResp : Bus::NULL);
      check("in_1.SResp", in_1_bus.SResp, (head == 1) ? out_bus.SResp : Bus::NULL);
      check("in_0.SData", in_0_bus.SData, (head == 0) ? out_bus.SData : 32'h0);
      check("in_1.SData", in_1_bus.SData, (head == 1) ? out_bus.SData : 32'h0);
      hacc = (head == 0) ? in_0_bus.MRespAccept : ((head == 1) ? in_1_bus.MRespAccept : 1'b0);
      check("out.MRespAccept", out_bus.MRespAccept, hacc);
      check("out.MReset_n", out_bus.MReset_n, 1'b1);
      if ((head >= 0) && (out_bus.SResp != Bus::NULL) && hacc) void'(q.pop_front());
      if (a0 || a1) begin
         q.push_back(owner);
         pref   = 1 - owner;
         locked = -1;
      end else if (fwd) begin
         locked = owner;
      end
   endtask

   initial begin
      forever begin
         @(negedge Clk);
         model_step();
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic drive_m(input int idx, input Bus::cmd_e c, input logic [31:0] a, input logic [31:0] d);
      if (idx == 0) begin
         in_0_bus.MCmd = c; in_0_bus.MAddr = a; in_0_bus.MData = d; in_0_bus.MByteEn = 4'hF;
      end else begin
         in_1_bus.MCmd = c; in_1_bus.MAddr = a; in_1_bus.MData = d; in_1_bus.MByteEn = 4'h3;
      end
   endtask

   task automatic slave_resp(input Bus::resp_e r, input logic [31:0] d);
      out_bus.SResp = r;
      out_bus.SData = d;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      drive_m(0, Bus::IDLE, 32'h0, 32'h0);
      drive_m(1, Bus::IDLE, 32'h0, 32'h0);
      out_bus.SCmdAccept = 1'b0;
      slave_resp(Bus::NULL, 32'h0);
      tick();
      tick();
      Reset = 1'b0;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      logic acc0, acc1;
      logic [31:0] a0, a1;
      int exp_g;
      in_0_bus.MRespAccept = 1'b1; in_0_bus.MReset_n = 1'b1;
      in_1_bus.MRespAccept = 1'b1; in_1_bus.MReset_n = 1'b1;
      do_reset();

      // 1: single read from in_0, response two cycles later
      settle();
      check("t1 reset count", 64'(dut.count), 64'd0);
      drive_m(0, Bus::RD, 32'h10, 32'h0);
      out_bus.SCmdAccept = 1'b1;
      settle();
      check("t1 out.MCmd", out_bus.MCmd, Bus::RD);
      check("t1 in_0 accept", in_0_bus.SCmdAccept, 1'b1);
      tick();
      drive_m(0, Bus::IDLE, 32'h0, 32'h0);
      settle();
      check("t1 count", 64'(dut.count), 64'd1);
      tick();
      slave_resp(Bus::DVA, 32'hA5A5_0001);
      settle();
      check("t1 in_0.SResp", in_0_bus.SResp, Bus::DVA);
      check("t1 in_0.SData", in_0_bus.SData, 32'hA5A5_0001);
      check("t1 in_1.SResp", in_1_bus.SResp, Bus::NULL);
      tick();
      slave_resp(Bus::NULL, 32'h0);
      settle();
      check("t1 count drained", 64'(dut.count), 64'd0);

      // 2: simultaneous requests, in-order responses
      do_reset();
      drive_m(0, Bus::WR, 32'h20, 32'h1111);
      drive_m(1, Bus::WR, 32'h24, 32'h2222);
      out_bus.SCmdAccept = 1'b1;
      settle();
      check("t2 c0 in_0 accept", in_0_bus.SCmdAccept, 1'b1);
      check("t2 c0 in_1 accept", in_1_bus.SCmdAccept, 1'b0);
      check("t2 c0 addr", out_bus.MAddr, 32'h20);
      tick();
      drive_m(0, Bus::IDLE, 32'h0, 32'h0);
      settle();
      check("t2 c1 in_1 accept", in_1_bus.SCmdAccept, 1'b1);
      check("t2 c1 data", out_bus.MData, 32'h2222);
      tick();
      drive_m(1, Bus::IDLE, 32'h0, 32'h0);
      slave_resp(Bus::DVA, 32'h0000_00A0);
      settle();
      check("t2 R0 on in_0", in_0_bus.SData, 32'h0000_00A0);
      check("t2 R0 not on in_1", in_1_bus.SResp, Bus::NULL);
      tick();
      slave_resp(Bus::DVA, 32'h0000_00A1);
      settle();
      check("t2 R1 on in_1", in_1_bus.SData, 32'h0000_00A1);
      check("t2 R1 not on in_0", in_0_bus.SResp, Bus::NULL);
      tick();
      slave_resp(Bus::NULL, 32'h0);

      // 3: lock held while slave stalls for 3 cycles
      do_reset();
      drive_m(0, Bus::RD, 32'h30, 32'h0);
      drive_m(1, Bus::RD, 32'h34, 32'h0);
      out_bus.SCmdAccept = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         check("t3 stall addr", out_bus.MAddr, 32'h30);
         check("t3 stall in_1 accept", in_1_bus.SCmdAccept, 1'b0);
         tick();
      end
      out_bus.SCmdAccept = 1'b1;
      settle();
      check("t3 c3 in_0 accept", in_0_bus.SCmdAccept, 1'b1);
      tick();
      drive_m(0, Bus::IDLE, 32'h0, 32'h0);
      settle();
      check("t3 c4 in_1 accept", in_1_bus.SCmdAccept, 1'b1);
      check("t3 c4 addr", out_bus.MAddr, 32'h34);
      tick();
      drive_m(1, Bus::IDLE, 32'h0, 32'h0);
      slave_resp(Bus::DVA, 32'h33);
      tick();
      tick();
      slave_resp(Bus::NULL, 32'h0);

      // 4: FIFO full blocks the fifth command until one pop has happened
      do_reset();
      out_bus.SCmdAccept = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_m(0, Bus::WR, 32'h40 + 32'(4 * i), 32'(i));
         settle();
         check("t4 fill accept", in_0_bus.SCmdAccept, 1'b1);
         tick();
      end
      drive_m(0, Bus::RD, 32'h50, 32'h0);
      settle();
      check("t4 full count", 64'(dut.count), 64'd4);
      check("t4 full MCmd", out_bus.MCmd, Bus::IDLE);
      check("t4 full accept", in_0_bus.SCmdAccept, 1'b0);
      tick();
      slave_resp(Bus::DVA, 32'h44);
      settle();
      check("t4 pop-cycle MCmd", out_bus.MCmd, Bus::IDLE);
      check("t4 pop-cycle MRespAccept", out_bus.MRespAccept, 1'b1);
      tick();
      slave_resp(Bus::NULL, 32'h0);
      settle();
      check("t4 after pop count", 64'(dut.count), 64'd3);
      check("t4 fifth MCmd", out_bus.MCmd, Bus::RD);
      check("t4 fifth addr", out_bus.MAddr, 32'h50);
      check("t4 fifth accept", in_0_bus.SCmdAccept, 1'b1);
      tick();
      drive_m(0, Bus::IDLE, 32'h0, 32'h0);
      slave_resp(Bus::DVA, 32'h45);
      for (int i = 0; i < 4; i++) tick();
      slave_resp(Bus::NULL, 32'h0);
      settle();
      check("t4 drained count", 64'(dut.count), 64'd0);

      // 5: reset with two commands outstanding
      do_reset();
      drive_m(0, Bus::WR, 32'h60, 32'h6);
      drive_m(1, Bus::WR, 32'h64, 32'h7);
      out_bus.SCmdAccept = 1'b1;
      tick();
      drive_m(0, Bus::IDLE, 32'h0, 32'h0);
      tick();
      drive_m(1, Bus::IDLE, 32'h0, 32'h0);
      settle();
      check("t5 in flight", 64'(dut.count), 64'd2);
      tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      slave_resp(Bus::DVA, 32'hDEAD);
      settle();
      check("t5 count cleared", 64'(dut.count), 64'd0);
      check("t5 late in_0.SResp", in_0_bus.SResp, Bus::NULL);
      check("t5 late in_1.SResp", in_1_bus.SResp, Bus::NULL);
      check("t5 late MRespAccept", out_bus.MRespAccept, 1'b0);
      tick();
      slave_resp(Bus::NULL, 32'h0);
      drive_m(0, Bus::RD, 32'h70, 32'h0);
      drive_m(1, Bus::RD, 32'h74, 32'h0);
      settle();
      check("t5 rr restart in_0", in_0_bus.SCmdAccept, 1'b1);
      check("t5 rr restart in_1", in_1_bus.SCmdAccept, 1'b0);
      tick();
      drive_m(0, Bus::IDLE, 32'h0, 32'h0);
      tick();
      drive_m(1, Bus::IDLE, 32'h0, 32'h0);
      slave_resp(Bus::DVA, 32'h77);
      tick();
      tick();
      slave_resp(Bus::NULL, 32'h0);

      // 6: eight back-to-back contended grants
      do_reset();
      out_bus.SCmdAccept = 1'b1;
      slave_resp(Bus::DVA, 32'hBEEF);
      a0 = 32'h100;
      a1 = 32'h200;
      drive_m(0, Bus::RD, a0, 32'h0);
      drive_m(1, Bus::RD, a1, 32'h0);
      for (int g = 0; g < 8; g++) begin
         settle();
         exp_g = FIXED ? 0 : (g % 2);
         check("t6 grant in_0", in_0_bus.SCmdAccept, (exp_g == 0) ? 1'b1 : 1'b0);
         check("t6 grant in_1", in_1_bus.SCmdAccept, (exp_g == 1) ? 1'b1 : 1'b0);
         acc0 = in_0_bus.SCmdAccept;
         acc1 = in_1_bus.SCmdAccept;
         tick();
         if (acc0) begin a0 = a0 + 32'd4; drive_m(0, Bus::RD, a0, 32'h0); end
         if (acc1) begin a1 = a1 + 32'd4; drive_m(1, Bus::RD, a1, 32'h0); end
      end
      drive_m(0, Bus::IDLE, 32'h0, 32'h0);
      drive_m(1, Bus::IDLE, 32'h0, 32'h0);
      tick();
      slave_resp(Bus::NULL, 32'h0);
      settle();
      check("t6 drained count", 64'(dut.count), 64'd0);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
